// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared regfile bus widths, constants and the write-request record used by
// the writeback controller and its FIFO.
package regfile_wb_ctrl_pkg;

  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_REG_NUM = 32;
  localparam int RF_FIFO_DEPTH = 2;

  localparam logic [RF_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic                 WE_ON     = 1'b1;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] waddr;
    logic [RF_DATA_W-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port
// is free. The caller guarantees no push when full and no pop when empty.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the count unchanged.
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port initiator: pipeline writeback has fixed priority
// over buffered long-latency results; a scoreboard tracks pending destinations.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int REG_NUM    = RF_REG_NUM,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid_i,
  input  logic [ADDR_W-1:0]  a_waddr_i,
  input  logic [DATA_W-1:0]  a_wdata_i,
  input  logic               b_valid_i,
  output logic               b_ready_o,
  input  logic [ADDR_W-1:0]  b_waddr_i,
  input  logic [DATA_W-1:0]  b_wdata_i,
  input  logic               iss_valid_i,
  input  logic [ADDR_W-1:0]  iss_waddr_i,
  input  logic [ADDR_W-1:0]  chk_raddr1_i,
  input  logic [ADDR_W-1:0]  chk_raddr2_i,
  output logic               stall_o,
  output logic [REG_NUM-1:0] pending_o,
  output logic               we_o,
  output logic [ADDR_W-1:0]  waddr_o,
  output logic [DATA_W-1:0]  wdata_o
);

  localparam int ENT_W = ADDR_W + DATA_W;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENT_W-1:0]   fifo_head;
  logic [ADDR_W-1:0]  head_waddr;
  logic [DATA_W-1:0]  head_wdata;
  logic [REG_NUM-1:0] pending_q, pending_d;

  assign {head_waddr, head_wdata} = fifo_head;

  // Ready depends only on registered occupancy; x0 results are accepted
  // by the handshake but dropped instead of enqueued.
  assign b_ready_o = !fifo_full;
  assign fifo_push = b_valid_i && b_ready_o && (b_waddr_i != '0);
  assign fifo_pop  = !rst && !a_valid_i && !fifo_empty;

  wb_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   ({b_waddr_i, b_wdata_i}),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    if (!rst) begin
      if (a_valid_i) begin
        we_o    = WE_ON;
        waddr_o = a_waddr_i;
        wdata_o = a_wdata_i;
      end else if (!fifo_empty) begin
        we_o    = WE_ON;
        waddr_o = head_waddr;
        wdata_o = head_wdata;
      end
    end
  end

  // Clear on pop first so a same-cycle reservation of that register wins.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) begin
      pending_d[head_waddr] = 1'b0;
    end
    if (iss_valid_i && (iss_waddr_i != '0)) begin
      pending_d[iss_waddr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign stall_o   = pending_q[chk_raddr1_i] | pending_q[chk_raddr2_i];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed cycle table, a reset-in-flight
// sequence, then random traffic against a queue-based reference model.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid_i;
  logic [4:0]  a_waddr_i;
  logic [31:0] a_wdata_i;
  logic        b_valid_i;
  logic        b_ready_o;
  logic [4:0]  b_waddr_i;
  logic [31:0] b_wdata_i;
  logic        iss_valid_i;
  logic [4:0]  iss_waddr_i;
  logic [4:0]  chk_raddr1_i;
  logic [4:0]  chk_raddr2_i;
  logic        stall_o;
  logic [31:0] pending_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  int errors = 0;
  int checks = 0;

  regfile_wb_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid_i    (a_valid_i),
    .a_waddr_i    (a_waddr_i),
    .a_wdata_i    (a_wdata_i),
    .b_valid_i    (b_valid_i),
    .b_ready_o    (b_ready_o),
    .b_waddr_i    (b_waddr_i),
    .b_wdata_i    (b_wdata_i),
    .iss_valid_i  (iss_valid_i),
    .iss_waddr_i  (iss_waddr_i),
    .chk_raddr1_i (chk_raddr1_i),
    .chk_raddr2_i (chk_raddr2_i),
    .stall_o      (stall_o),
    .pending_o    (pending_o),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus table ----------------
  typedef struct {
    logic        a_v;
    logic [4:0]  a_ad;
    logic [31:0] a_d;
    logic        b_v;
    logic [4:0]  b_ad;
    logic [31:0] b_d;
    logic        i_v;
    logic [4:0]  i_ad;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_we;
    logic [4:0]  e_ad;
    logic [31:0] e_d;
    logic        e_rdy;
    logic        e_stall;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic a_v, input logic [4:0] a_ad, input logic [31:0] a_d,
    input logic b_v, input logic [4:0] b_ad, input logic [31:0] b_d,
    input logic i_v, input logic [4:0] i_ad,
    input logic [4:0] c1, input logic [4:0] c2,
    input logic e_we, input logic [4:0] e_ad, input logic [31:0] e_d,
    input logic e_rdy, input logic e_stall, input logic [31:0] e_pend);
    vec_t v;
    v.a_v = a_v; v.a_ad = a_ad; v.a_d = a_d;
    v.b_v = b_v; v.b_ad = b_ad; v.b_d = b_d;
    v.i_v = i_v; v.i_ad = i_ad; v.c1 = c1; v.c2 = c2;
    v.e_we = e_we; v.e_ad = e_ad; v.e_d = e_d;
    v.e_rdy = e_rdy; v.e_stall = e_stall; v.e_pend = e_pend;
    return v;
  endfunction

  // ---------------- driver / scoreboard tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ia,
                       input logic [4:0] c1, input logic [4:0] c2);
    a_valid_i = av;  a_waddr_i = aa;  a_wdata_i = ad;
    b_valid_i = bv;  b_waddr_i = ba;  b_wdata_i = bd;
    iss_valid_i = iv; iss_waddr_i = ia;
    chk_raddr1_i = c1; chk_raddr2_i = c2;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic check_outs(input string tag, input logic e_we, input logic [4:0] e_ad,
                            input logic [31:0] e_d, input logic e_rdy,
                            input logic e_stall, input logic [31:0] e_pend);
    chk({tag, " we"},      32'(we_o),      32'(e_we));
    chk({tag, " waddr"},   32'(waddr_o),   32'(e_ad));
    chk({tag, " wdata"},   wdata_o,        e_d);
    chk({tag, " b_ready"}, 32'(b_ready_o), 32'(e_rdy));
    chk({tag, " stall"},   32'(stall_o),   32'(e_stall));
    chk({tag, " pending"}, pending_o,      e_pend);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model state ----------------
  wb_req_t     mq[$];
  logic [31:0] mpend;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // B-only write to x5 with decode checking x5
    vecs.push_back(mk(0,0,0, 0,0,0,            1,5, 5,0, 0,0,0,            1,0,32'h0));
    vecs.push_back(mk(0,0,0, 0,0,0,            0,0, 5,0, 0,0,0,            1,1,32'h20));
    vecs.push_back(mk(0,0,0, 1,5,32'hDEADBEEF, 0,0, 5,0, 0,0,0,            1,1,32'h20));
    vecs.push_back(mk(0,0,0, 0,0,0,            0,0, 5,0, 1,5,32'hDEADBEEF, 1,1,32'h20));
    vecs.push_back(mk(0,0,0, 0,0,0,            0,0, 5,0, 0,0,0,            1,0,32'h0));
    // A priority with B back-pressure
    vecs.push_back(mk(1,1,32'h11, 1,7,32'h77, 1,7, 7,8, 1,1,32'h11, 1,0,32'h0));
    vecs.push_back(mk(1,1,32'h11, 1,8,32'h88, 1,8, 7,8, 1,1,32'h11, 1,1,32'h80));
    vecs.push_back(mk(1,1,32'h11, 0,0,0,      0,0, 7,8, 1,1,32'h11, 0,1,32'h180));
    vecs.push_back(mk(1,1,32'h11, 0,0,0,      0,0, 7,8, 1,1,32'h11, 0,1,32'h180));
    vecs.push_back(mk(0,0,0,      0,0,0,      0,0, 7,8, 1,7,32'h77, 0,1,32'h180));
    vecs.push_back(mk(0,0,0,      0,0,0,      0,0, 7,8, 1,8,32'h88, 1,1,32'h100));
    vecs.push_back(mk(0,0,0,      0,0,0,      0,0, 7,8, 0,0,0,      1,0,32'h0));
    // set and clear of x9 in the same cycle
    vecs.push_back(mk(0,0,0, 0,0,0,       1,9, 9,0, 0,0,0,       1,0,32'h0));
    vecs.push_back(mk(0,0,0, 1,9,32'h99,  0,0, 9,0, 0,0,0,       1,1,32'h200));
    vecs.push_back(mk(0,0,0, 0,0,0,       1,9, 9,0, 1,9,32'h99,  1,1,32'h200));
    vecs.push_back(mk(0,0,0, 1,9,32'h9A,  0,0, 9,0, 0,0,0,       1,1,32'h200));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 9,0, 1,9,32'h9A,  1,1,32'h200));
    vecs.push_back(mk(0,0,0, 0,0,0,       0,0, 9,0, 0,0,0,       1,0,32'h0));
    // x0 handling
    vecs.push_back(mk(0,0,0,       1,0,32'h1234, 1,0, 0,0, 0,0,0,       1,0,32'h0));
    vecs.push_back(mk(0,0,0,       0,0,0,        0,0, 0,0, 0,0,0,       1,0,32'h0));
    vecs.push_back(mk(1,0,32'h55,  0,0,0,        0,0, 0,0, 1,0,32'h55,  1,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a_v, vecs[i].a_ad, vecs[i].a_d, vecs[i].b_v, vecs[i].b_ad,
            vecs[i].b_d, vecs[i].i_v, vecs[i].i_ad, vecs[i].c1, vecs[i].c2);
      #3;
      check_outs($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_ad, vecs[i].e_d,
                 vecs[i].e_rdy, vecs[i].e_stall, vecs[i].e_pend);
      next_cycle();
    end

    // Reset while the FIFO is full and x3/x4 are pending
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3, 5'd4);
    #3; check_outs("rst_c0", 1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 5'd3, 5'd4);
    #3; check_outs("rst_c1", 1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 32'h8);
    next_cycle();
    drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    rst = 1'b1;
    #3; check_outs("rst_c2", 1'b0, 5'd0, ZERO_WORD, 1'b0, 1'b1, 32'h18);
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    chk_raddr1_i = 5'd3; chk_raddr2_i = 5'd4;
    for (int k = 3; k < 6; k++) begin
      #3; check_outs($sformatf("rst_c%0d", k), 1'b0, 5'd0, ZERO_WORD, 1'b1, 1'b0, 32'h0);
      next_cycle();
    end

    // Random traffic against the reference model
    begin
      logic        av, bv, iv, hold, erdy, ewe;
      logic [4:0]  aa, ba, ia, c1, c2, ea;
      logic [31:0] ad, bd, ed;
      wb_req_t     r;
      mpend = '0;
      hold  = 1'b0;
      bv = 1'b0; ba = '0; bd = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        if (!hold) begin
          bv = 1'($urandom_range(0, 1));
          ba = 5'($urandom_range(0, 7));
          bd = $urandom;
        end
        av = ($urandom_range(0, 9) < 4);
        aa = 5'($urandom_range(0, 31));
        ad = $urandom;
        iv = ($urandom_range(0, 3) == 0);
        ia = 5'($urandom_range(0, 7));
        c1 = 5'($urandom_range(0, 7));
        c2 = 5'($urandom_range(0, 7));

        erdy = (mq.size() < RF_FIFO_DEPTH);
        if (av) begin
          ewe = 1'b1; ea = aa; ed = ad;
        end else if (mq.size() > 0) begin
          ewe = 1'b1; ea = mq[0].waddr; ed = mq[0].wdata;
        end else begin
          ewe = 1'b0; ea = '0; ed = ZERO_WORD;
        end

        drive(av, aa, ad, bv, ba, bd, iv, ia, c1, c2);
        #3;
        check_outs($sformatf("rnd%0d", cyc), ewe, ea, ed, erdy,
                   mpend[c1] | mpend[c2], mpend);

        if (!av && mq.size() > 0) begin
          mpend[mq[0].waddr] = 1'b0;
          void'(mq.pop_front());
        end
        if (bv && erdy && ba != 0) begin
          r.waddr = ba;
          r.wdata = bd;
          mq.push_back(r);
        end
        hold = bv && !erdy;
        if (iv && ia != 0) mpend[ia] = 1'b1;
        mpend[0] = 1'b0;
        next_cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-side initiator for the register file's single write port. Arbitrates between two sources and drives we/waddr/wdata into the regfile:
  - the in-order pipeline writeback (source A);
  - a long-latency unit such as load or mul (source B).
- Buffers source-B results in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on registers whose long-latency result has not yet been written.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, register address width.
- REG_NUM, 32, number of architectural registers; scoreboard width.
- FIFO_DEPTH, 2, source-B buffer entries; power of two, ≥2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid_i  in  1  pipeline writeback valid; no backpressure, always accepted.
- a_waddr_i  in  ADDR_W  pipeline destination register.
- a_wdata_i  in  DATA_W  pipeline result.
- b_valid_i  in  1  long-latency result valid.
- b_ready_o  out  1  FIFO can accept; handshake when b_valid_i & b_ready_o.
- b_waddr_i  in  ADDR_W  long-latency destination register.
- b_wdata_i  in  DATA_W  long-latency result.
- iss_valid_i  in  1  long-latency op issued; reserve destination.
- iss_waddr_i  in  ADDR_W  destination to reserve.
- chk_raddr1_i  in  ADDR_W  decode source operand 1.
- chk_raddr2_i  in  ADDR_W  decode source operand 2.
- stall_o  out  1  either checked source is pending.
- pending_o  out  REG_NUM  scoreboard bit vector.
- we_o  out  1  regfile write enable.
- waddr_o  out  ADDR_W  regfile write address.
- wdata_o  out  DATA_W  regfile write data.

Behaviour:
- Reset, synchronous and active-high:
  - FIFO emptied, pointers and count set to 0; scoreboard cleared.
  - Outputs next cycle: b_ready_o=1, stall_o=0, pending_o=0, we_o=0, waddr_o=0, wdata_o=0.
  - Reset mid-operation discards all buffered and pending writes; no write issues in the reset cycle.
- Write-port arbitration is combinational within one cycle, fixed priority:
  - If a_valid_i: we_o=1, waddr_o=a_waddr_i, wdata_o=a_wdata_i; the FIFO does not pop.
  - Else if FIFO non-empty: drive the FIFO head and pop it at the clock edge.
  - Else: we_o=0, waddr_o=0, wdata_o=0.
- Address-0 writes:
  - A with address 0 still drives we_o=1; the regfile ignores x0.
  - B with address 0 is accepted by the handshake but not enqueued.
- Source B latency:
  - A result accepted at edge N can appear on the write port at earliest cycle N+1.
  - It is delayed one cycle per cycle in which a_valid_i is high.
  - FIFO order is preserved.
- b_ready_o = (count < FIFO_DEPTH), registered-state based; no same-cycle pop-through.
  - When full, b_valid_i must hold its data until ready; source-B protocol requires this.
- Enqueue and pop in the same cycle: count unchanged, pointers advance mod FIFO_DEPTH.
- Scoreboard, one bit per register, bit 0 tied to 0:
  - Set at the edge where iss_valid_i and iss_waddr_i≠0.
  - Clear at the edge where a FIFO entry with that address is written to the regfile (popped).
  - Set and clear of the same bit in the same cycle: set wins (bit stays 1).
- stall_o = pending[chk_raddr1_i] | pending[chk_raddr2_i], from registered bits only.
  - This gives one conservative extra stall cycle in the pop cycle; the regfile's write-to-read forwarding then covers the first unstalled read.
- Source A writing a pending register is an issue-logic error. It is still written and the scoreboard is unchanged.
- Widths: FIFO pointers log2(FIFO_DEPTH) bits wrapping naturally; count log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package (same one as the regfile bus widths):
  - data width 32, address width 5, register count 32;
  - zero word;
  - write-enable level constant;
  - a wb_req_t struct {waddr, wdata}.
- One sub-module, wb_fifo: parameterised synchronous FIFO with push/pop, full/empty, and head data.
- Arbitration and the scoreboard stay in regfile_wb_ctrl.

Test Plan:
- Reset, then idle → we_o=0, b_ready_o=1, pending_o=0, stall_o=0.
- B-only write:
  - iss x5 at cycle 0 → pending_o[5]=1.
  - B pushes {x5, 0xDEADBEEF} at cycle 2 → we_o=1, waddr_o=5, wdata_o=0xDEADBEEF at cycle 3; pending_o[5]=0 at cycle 4.
  - chk_raddr1_i=5 → stall_o=1 through cycle 3 and 0 at cycle 4.
- Priority and back-pressure:
  - a_valid_i held high 4 cycles writing x1=0x11 while B pushes x7=0x77 and x8=0x88.
  - b_ready_o drops to 0 after two pushes; only A writes appear.
  - Then x7 and x8 are written in order in the next two cycles.
- Simultaneous set and clear: FIFO head pops for x9 in the same cycle iss_valid_i reserves x9 → pending_o[9] stays 1.
- x0 handling: iss x0 → pending_o[0]=0; B pushes {x0, 0x1234} → handshake completes, no regfile write occurs, FIFO count unchanged.
- Reset mid-operation: FIFO holds 2 entries and pending_o has bits 3 and 4 set; assert rst one cycle → next cycle we_o=0, pending_o=0, b_ready_o=1, and the old entries are never written.
